// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg: segment bit positions, hex code table and scan states.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g patterns, entry i draws hex digit i; shared with the encoder.
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } scan_state_e;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pattern_decode: active-low segment byte to hex value and flags.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] val,
  output logic       dp,
  output logic       blank,
  output logic       err
);

  logic [6:0] segs;
  logic       hit;

  assign segs = pattern[SEG_A:SEG_G];

  always_comb begin
    val   = 4'h0;
    dp    = ~pattern[SEG_DP];
    blank = 1'b0;
    err   = 1'b0;
    hit   = 1'b0;
    if (segs == SEG_BLANK) begin
      blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (segs == SEG_CODE[i]) begin
          val = 4'(i);
          hit = 1'b1;
        end
      end
      err = ~hit;
    end
  end

endmodule : seg_pattern_decode
`default_nettype wire

// File: rtl/seg_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_reader: debounces a multiplexed 7-seg bus and captures each |
// | digit's decoded value. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int NDIG          = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_n,
  input  logic [NDIG-1:0]           an_n,
  input  logic                      clr,
  output logic [4*NDIG-1:0]         digit_val,
  output logic [NDIG-1:0]           digit_dp,
  output logic [NDIG-1:0]           digit_blank,
  output logic [NDIG-1:0]           digit_err,
  output logic                      upd,
  output logic [$clog2(NDIG)-1:0]   upd_idx,
  output logic                      frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = $clog2(NDIG);
  localparam int SMP_W = NDIG + 8;

  logic [SMP_W-1:0] s_q;
  logic [SMP_W-1:0] sample;
  logic             changed;
  logic [CNT_W-1:0] cnt;
  logic             cnt_match;
  scan_state_e      state;
  scan_state_e      state_nxt;

  logic [NDIG-1:0]  an_low;
  logic             one_hot;
  logic [IDX_W-1:0] idx;
  logic             capture;
  logic             commit;
  logic [NDIG-1:0]  seen;
  logic [NDIG-1:0]  seen_nxt;
  logic             seen_full;

  logic [3:0]       dec_val;
  logic             dec_dp;
  logic             dec_blank;
  logic             dec_err;

  assign sample    = {an_n, seg_n};
  assign changed   = (sample != s_q);
  assign cnt_match = (cnt == CNT_W'(STABLE_CYCLES - 1));

  assign an_low  = ~s_q[SMP_W-1:8];
  assign one_hot = (an_low != '0) && ((an_low & (an_low - NDIG'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_low[i]) idx = IDX_W'(i);
    end
  end

  seg_pattern_decode u_decode (
    .pattern (s_q[7:0]),
    .val     (dec_val),
    .dp      (dec_dp),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '1;
      cnt   <= '0;
      state <= SETTLE;
    end else begin
      s_q   <= sample;
      state <= state_nxt;
      if (changed) begin
        cnt <= '0;
      end else if (state == SETTLE && !cnt_match) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (changed) begin
      state_nxt = SETTLE;
    end else if (state == SETTLE && cnt_match) begin
      state_nxt = HELD;
    end
  end

  // A window that closes without exactly one anode low is consumed silently.
  always_comb begin
    capture = 1'b0;
    if (state == SETTLE && !changed && cnt_match && one_hot) begin
      capture = 1'b1;
    end
  end

  assign commit    = capture && !clr;
  assign seen_nxt  = seen | (NDIG'(1) << idx);
  assign seen_full = &seen_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val   <= '0;
      digit_dp    <= '0;
      digit_blank <= '1;
      digit_err   <= '0;
      seen        <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      frame_done  <= 1'b0;
    end else begin
      upd        <= commit;
      frame_done <= commit && seen_full;
      if (clr) begin
        digit_val   <= '0;
        digit_dp    <= '0;
        digit_blank <= '1;
        digit_err   <= '0;
        seen        <= '0;
      end else if (capture) begin
        upd_idx <= idx;
        seen    <= seen_full ? '0 : seen_nxt;
        for (int i = 0; i < NDIG; i++) begin
          if (idx == IDX_W'(i)) begin
            digit_val[4*i +: 4] <= dec_val;
            digit_dp[i]         <= dec_dp;
            digit_blank[i]      <= dec_blank;
            digit_err[i]        <= dec_err;
          end
        end
      end
    end
  end

endmodule : seg_scan_reader
`default_nettype wire

// File: tb/tb_seg_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_reader: table-driven scan windows with an upd scoreboard.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seg_scan_reader;

  localparam int NDIG   = 8;
  localparam int STABLE = 4;

  logic              clk;
  logic              rst_n;
  logic [7:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic              clr;
  logic [4*NDIG-1:0] digit_val;
  logic [NDIG-1:0]   digit_dp;
  logic [NDIG-1:0]   digit_blank;
  logic [NDIG-1:0]   digit_err;
  logic              upd;
  logic [2:0]        upd_idx;
  logic              frame_done;

  seg_scan_reader #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clr         (clr),
    .digit_val   (digit_val),
    .digit_dp    (digit_dp),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    int         hold;
    bit         upd;
    logic [2:0] idx;
    logic [3:0] val;
    bit         dp;
    bit         blank;
    bit         err;
    bit         fd;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [3:0] val;
    bit         dp;
    bit         blank;
    bit         err;
    bit         fd;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   cyc;
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] an, input logic [7:0] seg, input int hold,
                              input bit u, input logic [2:0] idx, input logic [3:0] val,
                              input bit dp, input bit blank, input bit err, input bit fd);
    vec_t v;
    v.an = an; v.seg = seg; v.hold = hold; v.upd = u; v.idx = idx; v.val = val;
    v.dp = dp; v.blank = blank; v.err = err; v.fd = fd;
    return v;
  endfunction

  // Called on a falling edge; the capture shows up STABLE+1 cycles later.
  task automatic present(input logic [7:0] an, input logic [7:0] seg);
    an_n  = an;
    seg_n = seg;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    present(v.an, v.seg);
    if (v.upd) begin
      e.cyc = cyc + STABLE + 1; e.idx = v.idx; e.val = v.val;
      e.dp = v.dp; e.blank = v.blank; e.err = v.err; e.fd = v.fd;
      sbq.push_back(e);
    end
    repeat (v.hold) @(negedge clk);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec(tbl[i]);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (upd === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("upd_unexpected", {63'd0, upd}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("upd_cycle", 64'(cyc), 64'(e.cyc));
        chk("upd_idx", 64'(upd_idx), 64'(e.idx));
        chk("digit_val", 64'(digit_val[4*e.idx +: 4]), 64'(e.val));
        chk("digit_dp", 64'(digit_dp[e.idx]), 64'(e.dp));
        chk("digit_blank", 64'(digit_blank[e.idx]), 64'(e.blank));
        chk("digit_err", 64'(digit_err[e.idx]), 64'(e.err));
        chk("frame_done", 64'(frame_done), 64'(e.fd));
      end
    end else begin
      if (frame_done === 1'b1) chk("fd_without_upd", 64'(frame_done), 64'd0);
      if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
        chk("upd_missing", 64'(upd), 64'd1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int rel_cyc;
    exp_t e;
    checks = 0;
    errors = 0;

    // 0..0 : single stable digit 0 shows "0"
    tbl.push_back(mk(8'hFE, 8'h03, 10, 1, 3'd0, 4'h0, 0, 0, 0, 0));
    // 1..8 : scan digits 0..7 showing 1..8, dp on digit 3
    tbl.push_back(mk(8'hFE, 8'h9F, 6, 1, 3'd0, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFD, 8'h25, 6, 1, 3'd1, 4'h2, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFB, 8'h0D, 6, 1, 3'd2, 4'h3, 0, 0, 0, 0));
    tbl.push_back(mk(8'hF7, 8'h98, 6, 1, 3'd3, 4'h4, 1, 0, 0, 0));
    tbl.push_back(mk(8'hEF, 8'h49, 6, 1, 3'd4, 4'h5, 0, 0, 0, 0));
    tbl.push_back(mk(8'hDF, 8'h41, 6, 1, 3'd5, 4'h6, 0, 0, 0, 0));
    tbl.push_back(mk(8'hBF, 8'h1F, 6, 1, 3'd6, 4'h7, 0, 0, 0, 0));
    tbl.push_back(mk(8'h7F, 8'h01, 6, 1, 3'd7, 4'h8, 0, 0, 0, 1));
    // 9..18 : glitching every 2 cycles, then 19 stable "2"
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(8'hFE, (i % 2 == 0) ? 8'h03 : 8'h9F, 2, 0, 3'd0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFE, 8'h25, 8, 1, 3'd0, 4'h2, 0, 0, 0, 0));
    // 20..21 : two anodes low, then blank on digit 1
    tbl.push_back(mk(8'hFC, 8'h25, 10, 0, 3'd0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFD, 8'hFF, 8, 1, 3'd1, 4'h0, 0, 1, 0, 0));
    // 22 : unknown pattern on digit 2 (dp bit low)
    tbl.push_back(mk(8'hFB, 8'hAA, 8, 1, 3'd2, 4'h0, 1, 0, 1, 0));
    // 23..30 : after clr, digits 0,1,3..7 then 2 completes the frame
    tbl.push_back(mk(8'hFE, 8'h09, 6, 1, 3'd0, 4'h9, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFD, 8'h11, 6, 1, 3'd1, 4'hA, 0, 0, 0, 0));
    tbl.push_back(mk(8'hF7, 8'hC1, 6, 1, 3'd3, 4'hB, 0, 0, 0, 0));
    tbl.push_back(mk(8'hEF, 8'h63, 6, 1, 3'd4, 4'hC, 0, 0, 0, 0));
    tbl.push_back(mk(8'hDF, 8'h85, 6, 1, 3'd5, 4'hD, 0, 0, 0, 0));
    tbl.push_back(mk(8'hBF, 8'h61, 6, 1, 3'd6, 4'hE, 0, 0, 0, 0));
    tbl.push_back(mk(8'h7F, 8'h71, 6, 1, 3'd7, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFB, 8'h03, 8, 1, 3'd2, 4'h0, 0, 0, 0, 1));

    rst_n = 1'b1;
    clr   = 1'b0;
    an_n  = 8'hFF;
    seg_n = 8'hFF;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digit_val", 64'(digit_val), 64'd0);
    chk("rst_digit_blank", 64'(digit_blank), 64'hFF);
    chk("rst_digit_dp", 64'(digit_dp), 64'd0);
    chk("rst_digit_err", 64'(digit_err), 64'd0);
    chk("rst_upd", 64'(upd), 64'd0);
    chk("rst_upd_idx", 64'(upd_idx), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    run_range(0, 8);
    chk("scan_digit_val", 64'(digit_val), 64'h87654321);
    chk("scan_digit_dp", 64'(digit_dp), 64'h08);
    chk("scan_digit_blank", 64'(digit_blank), 64'h00);

    run_range(9, 21);
    chk("after_blank_val", 64'(digit_val), 64'h87654302);
    chk("after_blank_blank", 64'(digit_blank), 64'h02);

    run_range(22, 22);
    chk("unknown_err", 64'(digit_err), 64'h04);

    // clr lands on the same edge as a digit-5 capture
    present(8'hDF, 8'h41);
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("clr_digit_val", 64'(digit_val), 64'd0);
    chk("clr_digit_err", 64'(digit_err), 64'd0);
    chk("clr_digit_blank", 64'(digit_blank), 64'hFF);
    chk("clr_digit_dp", 64'(digit_dp), 64'd0);

    run_range(23, 30);
    chk("frame2_digit_val", 64'(digit_val), 64'hFEDCB0A9);
    chk("frame2_digit_blank", 64'(digit_blank), 64'h00);

    // reset while the counter sits at 2, then a full window after release
    present(8'hFE, 8'h9F);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_digit_val", 64'(digit_val), 64'd0);
    chk("midrst_digit_blank", 64'(digit_blank), 64'hFF);
    chk("midrst_upd", 64'(upd), 64'd0);
    chk("midrst_upd_idx", 64'(upd_idx), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    e.cyc = rel_cyc + STABLE + 1; e.idx = 3'd0; e.val = 4'h1;
    e.dp = 0; e.blank = 0; e.err = 0; e.fd = 0;
    sbq.push_back(e);
    repeat (10) @(negedge clk);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seg_scan_reader
`default_nettype wire

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Observes a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) and reconstructs the value shown on each digit.
- It is the decode direction of the team's segment encoder. It sits beside the display driver as a self-check and capture block, and as the front end for the bench's display scoreboard.
- Each digit's pattern is debounced, mapped back to a 4-bit hex value with dp/blank/error flags, stored per digit, and announced with update and frame-done pulses.

Parameters:
- NDIG, 8, number of multiplexed digits (2..16).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255).
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  8  segment lines, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
- an_n  in  NDIG  digit enables, active-low; a valid scan slot has exactly one bit low.
- clr  in  1  synchronous clear of captured digits and frame mask.
- digit_val  out  4*NDIG  decoded value per digit; digit i occupies bits [4i+3:4i].
- digit_dp  out  NDIG  decimal point lit per digit.
- digit_blank  out  NDIG  digit pattern was all-off (seg_n[7:1]=7'h7F).
- digit_err  out  NDIG  pattern not in the code table and not blank.
- upd  out  1  one-cycle pulse: a digit was captured.
- upd_idx  out  $clog2(NDIG)  index of the digit captured with upd.
- frame_done  out  1  one-cycle pulse: every digit captured at least once since the last frame_done/clr/reset.

Behaviour:
- Reset (async assert, sync release):
  - all digit_val=0, digit_dp=0, digit_blank=all 1s, digit_err=0;
  - upd=0, upd_idx=0, frame_done=0;
  - sample register = all 1s, counter=0, seen mask=0, state SETTLE.
- Input stage: {an_n,seg_n} is registered every cycle into s_q. If the new sample differs from s_q, the counter goes to 0 and the state goes to SETTLE.
- State SETTLE: the counter increments on each identical sample. When it reaches STABLE_CYCLES-1:
  - if an_n is one-hot-low, capture the decoded pattern into digit[idx], pulse upd, set seen[idx], go to HELD;
  - otherwise (zero or multiple anodes low), go to HELD without capture.
- State HELD: no further capture until the sample changes, so each stable window captures at most once. A display dwelling on one digit produces exactly one upd.
- Latency: a pattern first presented in cycle t and held gives upd=1 in cycle t+STABLE_CYCLES+1 (registered outputs). digit_* reflect the new value in that same cycle.
- Decode ignores bit0 (dp). Codes for seg_n[7:1]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111;
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - 1111111 means blank: val=0, blank=1.
  - Any other pattern: val=0, err=1.
  - dp=~seg_n[0].
- frame_done: when a capture makes the seen mask all ones, frame_done pulses in the same cycle as that upd. The mask then clears; the bit for that capture is not retained.
- clr: zeroes digit_val/dp/err, sets blank, and clears the seen mask in the next cycle. If clr coincides with a capture, clr wins: no upd, no frame_done. The debounce state is unaffected.
- A change arriving on the cycle the counter would have matched aborts that capture.
- Mid-operation reset: immediate return to reset values. No stale upd is emitted after release.

Decomposition:
- Shared package seg_pkg holds:
  - the segment bit-position constants, SEG_BLANK=7'h7F, and the 16-entry hex-to-segment code table (shared with the encoder);
  - the state enum {SETTLE, HELD}.
- One natural sub-module, seg_pattern_decode: combinational 8-bit pattern to {val[3:0], dp, blank, err}. Equivalence-checkable against the encoder.

Test Plan:
1. Reset, then hold an_n=8'hFE, seg_n=8'h03 for 10 cycles -> single upd at cycle 5 after presentation; upd_idx=0, digit_val[3:0]=0, blank=0, err=0.
2. Scan digits 0..7 showing 1..8, 6 cycles each, seg_n per table, dp lit on digit 3 -> eight upd pulses; frame_done coincides with the idx=7 upd; digit_val=32'h87654321; digit_dp=8'h08.
3. Glitch: change seg_n every 2 cycles for 20 cycles on a fixed anode -> no upd. Then stable 8'h25 -> one upd with val=2.
4. an_n=8'hFC (two low) held 10 cycles -> no upd, digits unchanged. Then seg_n=8'hFF on an_n=8'hFD -> upd idx=1, blank[1]=1.
5. Unknown pattern seg_n=8'hAA on digit 2 -> upd, err[2]=1, val=0. Then clr coincident with a digit-5 capture -> no upd, all err=0, blank=all 1s, seen mask empty.
6. Assert rst_n low for 1 cycle mid-settle (counter=2) -> outputs at reset values; after release, the same stable input captures after a full STABLE_CYCLES window.
